record_table_engine: RTL and testbench

- Parametrised record lookup table of DEPTH entries. Each entry is a record {hex, aval}; a tag field is derived from the index.
- Entries load from constant defaults on reset and can be overwritten at run time.
- Reads are served through a valid/ready request/response pipeline.
- An autonomous scan mode streams every entry in index order. Sits behind mixed-language record/constant-array test fixtures as the sequential generalisation of a combinational constant-record select.

---
 rtl/record_table_engine_if.sv | 37 +++
 rtl/record_table_engine.sv | 143 ++++++++++++++
 tb/tb_record_table_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/record_table_engine_if.sv
// Handshake and table-write bundle for record_table_engine.
// The slave side is the engine; the master side is whoever drives requests/writes.
interface record_table_engine_if #(
   parameter int SEL_W = 2,
   parameter int W     = 8
);
   logic             wr_en;
   logic [SEL_W-1:0] wr_addr;
   logic [W-1:0]     wr_hex;
   logic [W-1:0]     wr_aval;
   logic             req_valid;
   logic             req_ready;
   logic [SEL_W-1:0] req_sel;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_hex;
   logic [W-1:0]     rsp_aval;
   logic [W-1:0]     rsp_tag;
   logic             rsp_err;
   logic             scan_start;
   logic             scan_busy;
   logic             scan_done;

   modport slave (
      input  wr_en, wr_addr, wr_hex, wr_aval,
      input  req_valid, req_sel, rsp_ready, scan_start,
      output req_ready, rsp_valid, rsp_hex, rsp_aval, rsp_tag, rsp_err,
      output scan_busy, scan_done
   );

   modport master (
      output wr_en, wr_addr, wr_hex, wr_aval,
      output req_valid, req_sel, rsp_ready, scan_start,
      input  req_ready, rsp_valid, rsp_hex, rsp_aval, rsp_tag, rsp_err,
      input  scan_busy, scan_done
   );
endinterface

// File: rtl/record_table_engine.sv
// Record lookup table {hex, aval} with derived tag, served through a
// one-deep registered valid/ready response stage, plus an autonomous
// scan that streams every entry in index order through the same stage.
module record_table_engine #(
   parameter int DEPTH = 4,
   parameter int SEL_W = 2,
   parameter int W     = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   record_table_engine_if.slave bus
);
   // wide enough that 0x11*sel never overflows before truncation to W
   localparam int TW = W + SEL_W + 8;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state;
   logic [W-1:0]     hex_q  [DEPTH];
   logic [W-1:0]     aval_q [DEPTH];
   logic [SEL_W-1:0] scan_idx;
   logic             issued_all;  // scan has issued its final index
   logic             rsp_last;    // held response is the scan's final entry

   logic             slot_free;
   logic             fire;
   logic             scan_issue;
   logic             issue;
   logic [SEL_W-1:0] isel;
   logic [W-1:0]     rd_hex;
   logic [W-1:0]     rd_aval;
   logic             rd_err;
   logic [TW-1:0]    tag_prod;

   function automatic logic [W-1:0] def_hex(input int i);
      return W'((i + 1) * 16 + 4);
   endfunction

   function automatic logic [W-1:0] def_aval(input int i);
      return W'(32'hAA + 32'h11 * i);
   endfunction

   // response slot can take a new entry when empty or being drained this cycle
   assign slot_free     = !bus.rsp_valid || bus.rsp_ready;
   // scan_start wins over a simultaneous external request
   assign bus.req_ready = slot_free && (state == IDLE) && !bus.scan_start;
   assign fire          = bus.req_valid && bus.req_ready;
   assign scan_issue    = (state == SCAN) && !issued_all && slot_free;
   assign issue         = fire || scan_issue;
   assign isel          = scan_issue ? scan_idx : bus.req_sel;
   assign tag_prod      = TW'(17) * TW'(isel);

   // table read mux; any index without a matching entry is out of range
   always_comb begin
      rd_hex  = '0;
      rd_aval = '0;
      rd_err  = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (isel == SEL_W'(i)) begin
            rd_hex  = hex_q[i];
            rd_aval = aval_q[i];
            rd_err  = 1'b0;
         end
      end
   end

   // table storage: defaults on reset, run-time overwrite of in-range entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            hex_q[i]  <= def_hex(i);
            aval_q[i] <= def_aval(i);
         end
      end else if (bus.wr_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.wr_addr == SEL_W'(i)) begin
               hex_q[i]  <= bus.wr_hex;
               aval_q[i] <= bus.wr_aval;
            end
         end
      end
   end

   // response register: load on issue, hold while stalled, drop on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_hex   <= '0;
         bus.rsp_aval  <= '0;
         bus.rsp_tag   <= '0;
         bus.rsp_err   <= 1'b0;
         rsp_last      <= 1'b0;
      end else if (issue) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_hex   <= rd_hex;
         bus.rsp_aval  <= rd_aval;
         bus.rsp_tag   <= tag_prod[W-1:0];
         bus.rsp_err   <= rd_err;
         rsp_last      <= scan_issue && (scan_idx == SEL_W'(DEPTH - 1));
      end else if (bus.rsp_ready) begin
         bus.rsp_valid <= 1'b0;
      end
   end

   // scan FSM: walk indices 0..DEPTH-1, finish when the last one is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         scan_idx      <= '0;
         issued_all    <= 1'b0;
         bus.scan_busy <= 1'b0;
         bus.scan_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.scan_done <= 1'b0;
               if (bus.scan_start) begin
                  state         <= SCAN;
                  scan_idx      <= '0;
                  issued_all    <= 1'b0;
                  bus.scan_busy <= 1'b1;
               end
            end
            SCAN: begin
               if (scan_issue) begin
                  if (scan_idx == SEL_W'(DEPTH - 1)) issued_all <= 1'b1;
                  else                               scan_idx   <= scan_idx + 1'b1;
               end
               if (bus.rsp_valid && bus.rsp_ready && rsp_last) begin
                  state         <= DONE;
                  bus.scan_busy <= 1'b0;
                  bus.scan_done <= 1'b1;
               end
            end
            DONE: begin
               state         <= IDLE;
               bus.scan_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_record_table_engine.sv
// Self-checking bench: directed scenarios plus a randomized read/write run
// against a table/handshake reference model held in the bench.
module tb_record_table_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   record_table_engine_if #(.SEL_W(2), .W(8)) ifa ();
   record_table_engine_if #(.SEL_W(3), .W(8)) ifb ();

   record_table_engine #(.DEPTH(4), .SEL_W(2), .W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   record_table_engine #(.DEPTH(5), .SEL_W(3), .W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   int n_vec = 0;
   int n_err = 0;

   // reference table for the DEPTH=4 instance
   logic [7:0] m_hex  [4];
   logic [7:0] m_aval [4];

   // observed response of each instance as {valid, err, hex, aval, tag}
   logic [25:0] act_a, act_b;
   assign act_a = {ifa.rsp_valid, ifa.rsp_err, ifa.rsp_hex, ifa.rsp_aval, ifa.rsp_tag};
   assign act_b = {ifb.rsp_valid, ifb.rsp_err, ifb.rsp_hex, ifb.rsp_aval, ifb.rsp_tag};

   function automatic logic [7:0] spec_hex(input int i);
      return 8'((i + 1) * 16 + 4);
   endfunction
   function automatic logic [7:0] spec_aval(input int i);
      return 8'(170 + 17 * i);
   endfunction
   function automatic logic [7:0] spec_tag(input int s);
      return 8'(17 * s);
   endfunction

   // expected valid response of instance A for index s from the model table
   function automatic logic [25:0] exp_a(input int s);
      return {1'b1, 1'b0, m_hex[s], m_aval[s], spec_tag(s)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_hex[i]  = spec_hex(i);
         m_aval[i] = spec_aval(i);
      end
   endtask

   task automatic quiet(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ifa.req_valid = 0; ifa.wr_en = 0; ifa.scan_start = 0; ifa.rsp_ready = 1;
         ifb.req_valid = 0; ifb.wr_en = 0; ifb.scan_start = 0; ifb.rsp_ready = 1;
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if (act_a !== 26'd0 || ifa.scan_busy !== 1'b0 || ifa.scan_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs_a: got rsp=%h busy=%b done=%b, want all 0", act_a, ifa.scan_busy, ifa.scan_done);
      end
      n_vec++;
      if (act_b !== 26'd0 || ifb.scan_busy !== 1'b0 || ifb.scan_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs_b: got rsp=%h busy=%b done=%b, want all 0", act_b, ifb.scan_busy, ifb.scan_done);
      end
      n_vec++;
      if (ifa.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_req_ready: got %b, want 1", ifa.req_ready);
      end
   endtask

   // back-to-back reads 0..3, each response one cycle after its fire
   task automatic test_basic_reads();
      quiet(2);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         ifa.req_valid = (i < 4);
         ifa.req_sel   = 2'(i);
         #1;
         if (i < 4) begin
            n_vec++;
            if (ifa.req_ready !== 1'b1) begin
               n_err++;
               $display("FAIL basic_ready sel=%0d: got %b, want 1", i, ifa.req_ready);
            end
         end
         if (i > 0) begin
            n_vec++;
            if (act_a !== exp_a(i - 1)) begin
               n_err++;
               $display("FAIL basic_rsp sel=%0d: got %h, want %h", i - 1, act_a, exp_a(i - 1));
            end
         end
      end
   endtask

   // same-cycle write and read of one index returns the old data
   task automatic test_collision();
      logic [25:0] old_rsp, new_rsp;
      quiet(1);
      old_rsp = exp_a(3);
      @(negedge clk);
      ifa.wr_en = 1; ifa.wr_addr = 2'd3; ifa.wr_hex = 8'h56; ifa.wr_aval = 8'hEE;
      ifa.req_valid = 1; ifa.req_sel = 2'd3;
      m_hex[3] = 8'h56; m_aval[3] = 8'hEE;
      new_rsp = exp_a(3);
      @(negedge clk);
      ifa.wr_en = 0;
      #1;
      n_vec++;
      if (act_a !== old_rsp) begin
         n_err++;
         $display("FAIL collision_old: got %h, want %h", act_a, old_rsp);
      end
      @(negedge clk);
      ifa.req_valid = 0;
      #1;
      n_vec++;
      if (act_a !== new_rsp) begin
         n_err++;
         $display("FAIL collision_new: got %h, want %h", act_a, new_rsp);
      end
   endtask

   // consumer stall holds the response and blocks new requests
   task automatic test_stall();
      quiet(2);
      @(negedge clk);
      ifa.req_valid = 1; ifa.req_sel = 2'd1; ifa.rsp_ready = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ifa.rsp_ready = 0; ifa.req_sel = 2'd2;
         #1;
         n_vec++;
         if (act_a !== exp_a(1) || ifa.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold c=%0d: got rsp=%h ready=%b, want rsp=%h ready=0", c, act_a, ifa.req_ready, exp_a(1));
         end
      end
      @(negedge clk);
      ifa.rsp_ready = 1;
      #1;
      n_vec++;
      if (act_a !== exp_a(1) || ifa.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL stall_release: got rsp=%h ready=%b, want rsp=%h ready=1", act_a, ifa.req_ready, exp_a(1));
      end
      @(negedge clk);
      ifa.req_valid = 0;
      #1;
      n_vec++;
      if (act_a !== exp_a(2)) begin
         n_err++;
         $display("FAIL stall_next: got %h, want %h", act_a, exp_a(2));
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (ifa.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stall_single_fire: rsp_valid got %b, want 0", ifa.rsp_valid);
      end
   endtask

   // random reads/writes/backpressure against the reference model
   task automatic test_random();
      bit          e_valid = 0;
      logic [25:0] e_rsp = '0;
      bit          e_ready, fire;
      int          sel, wa;
      quiet(2);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         ifa.rsp_ready = ($urandom_range(0, 3) != 0);
         ifa.req_valid = $urandom_range(0, 1);
         sel           = $urandom_range(0, 3);
         ifa.req_sel   = 2'(sel);
         ifa.wr_en     = ($urandom_range(0, 3) == 0);
         wa            = $urandom_range(0, 3);
         ifa.wr_addr   = 2'(wa);
         ifa.wr_hex    = 8'($urandom);
         ifa.wr_aval   = 8'($urandom);
         #1;
         e_ready = !e_valid || ifa.rsp_ready;
         n_vec++;
         if (ifa.req_ready !== e_ready) begin
            n_err++;
            $display("FAIL rand_ready c=%0d: got %b, want %b", c, ifa.req_ready, e_ready);
         end
         n_vec++;
         if (ifa.rsp_valid !== e_valid || (e_valid && act_a !== e_rsp)) begin
            n_err++;
            $display("FAIL rand_rsp c=%0d: got %h, want valid=%b rsp=%h", c, act_a, e_valid, e_rsp);
         end
         fire = ifa.req_valid && e_ready;
         if (fire) begin
            e_valid = 1;
            e_rsp   = exp_a(sel);
         end else if (ifa.rsp_ready) begin
            e_valid = 0;
         end
         if (ifa.wr_en) begin
            m_hex[wa]  = ifa.wr_hex;
            m_aval[wa] = ifa.wr_aval;
         end
      end
      quiet(2);
   endtask

   // scan behind a held response, with toggling backpressure and a blocked request
   task automatic test_scan();
      logic [25:0] q[$];
      logic [25:0] e;
      int since = -1;
      quiet(2);
      @(negedge clk);
      ifa.req_valid = 1; ifa.req_sel = 2'd2; ifa.rsp_ready = 0;
      q.push_back(exp_a(2));
      @(negedge clk);
      ifa.scan_start = 1; ifa.req_sel = 2'd1;
      for (int i = 0; i < 4; i++) q.push_back(exp_a(i));
      for (int c = 0; c < 60 && since < 3; c++) begin
         @(negedge clk);
         ifa.scan_start = 0;
         ifa.rsp_ready  = (c % 2 == 0);
         if (since >= 1) ifa.req_valid = 0;
         #1;
         if (since <= 1) begin
            n_vec++;
            if (ifa.req_ready !== 1'b0) begin
               n_err++;
               $display("FAIL scan_req_blocked c=%0d: req_ready got %b, want 0", c, ifa.req_ready);
            end
         end
         n_vec++;
         if (ifa.scan_busy !== (since < 1) || ifa.scan_done !== (since == 1)) begin
            n_err++;
            $display("FAIL scan_flags c=%0d: got busy=%b done=%b, want busy=%b done=%b",
                     c, ifa.scan_busy, ifa.scan_done, since < 1, since == 1);
         end
         if (ifa.rsp_valid && ifa.rsp_ready) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL scan_extra_rsp c=%0d: got %h, want no response", c, act_a);
            end else begin
               e = q.pop_front();
               if (act_a !== e) begin
                  n_err++;
                  $display("FAIL scan_order c=%0d: got %h, want %h", c, act_a, e);
               end
               if (q.size() == 0) since = 0;
            end
         end
         if (since >= 0) since++;
      end
      n_vec++;
      if (since < 3) begin
         n_err++;
         $display("FAIL scan_timeout: %0d responses outstanding, done stage %0d, want completion", q.size(), since);
      end
      quiet(2);
   endtask

   // DEPTH=5 instance: out-of-range reads and ignored out-of-range writes
   task automatic test_out_of_range();
      logic [25:0] e;
      quiet(1);
      @(negedge clk);
      ifb.wr_en = 1; ifb.wr_addr = 3'd7; ifb.wr_hex = 8'hFF; ifb.wr_aval = 8'hFF;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         ifb.wr_en     = 0;
         ifb.req_valid = (i < 8);
         ifb.req_sel   = 3'(i);
         #1;
         if (i > 0) begin
            e = (i - 1 < 5) ? {2'b10, spec_hex(i - 1), spec_aval(i - 1), spec_tag(i - 1)}
                            : {2'b11, 16'h0, spec_tag(i - 1)};
            n_vec++;
            if (act_b !== e) begin
               n_err++;
               $display("FAIL range_rsp sel=%0d: got %h, want %h", i - 1, act_b, e);
            end
         end
      end
      quiet(1);
   endtask

   // reset in the middle of a scan after a user overwrite
   task automatic test_reset_mid_scan();
      int acc = 0;
      quiet(2);
      @(negedge clk);
      ifa.wr_en = 1; ifa.wr_addr = 2'd2; ifa.wr_hex = 8'h77; ifa.wr_aval = 8'h99;
      @(negedge clk);
      ifa.wr_en = 0;
      ifa.scan_start = 1; ifa.req_valid = 1; ifa.req_sel = 2'd0; ifa.rsp_ready = 1;
      #1;
      n_vec++;
      if (ifa.req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL scan_wins: req_ready got %b, want 0", ifa.req_ready);
      end
      for (int c = 0; c < 20 && acc < 2; c++) begin
         @(negedge clk);
         ifa.scan_start = 0; ifa.req_valid = 0;
         #1;
         if (ifa.rsp_valid && ifa.rsp_ready) acc++;
      end
      n_vec++;
      if (acc < 2 || ifa.scan_busy !== 1'b1) begin
         n_err++;
         $display("FAIL midscan_progress: accepted %0d busy=%b, want 2 and busy=1", acc, ifa.scan_busy);
      end
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      n_vec++;
      if (act_a !== 26'd0 || ifa.scan_busy !== 1'b0 || ifa.scan_done !== 1'b0) begin
         n_err++;
         $display("FAIL midscan_reset: got rsp=%h busy=%b done=%b, want all 0", act_a, ifa.scan_busy, ifa.scan_done);
      end
      @(negedge clk);
      rst_n = 1;
      model_reset();
      @(negedge clk);
      ifa.req_valid = 1; ifa.req_sel = 2'd2;
      #1;
      n_vec++;
      if (ifa.req_ready !== 1'b1 || ifa.scan_busy !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: ready=%b busy=%b, want ready=1 busy=0", ifa.req_ready, ifa.scan_busy);
      end
      @(negedge clk);
      ifa.req_valid = 0;
      #1;
      n_vec++;
      if (act_a !== {2'b10, 8'h34, 8'hCC, 8'h22}) begin
         n_err++;
         $display("FAIL post_reset_entry2: got %h, want %h", act_a, {2'b10, 8'h34, 8'hCC, 8'h22});
      end
   endtask

   initial begin
      ifa.wr_en = 0; ifa.wr_addr = '0; ifa.wr_hex = '0; ifa.wr_aval = '0;
      ifa.req_valid = 0; ifa.req_sel = '0; ifa.rsp_ready = 1; ifa.scan_start = 0;
      ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_hex = '0; ifb.wr_aval = '0;
      ifb.req_valid = 0; ifb.req_sel = '0; ifb.rsp_ready = 1; ifb.scan_start = 0;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      @(negedge clk);
      rst_n = 1;
      test_basic_reads();
      test_collision();
      test_stall();
      test_random();
      test_scan();
      test_out_of_range();
      test_reset_mid_scan();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
